// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: command-driven front-end for the 16-bit combinational ALU.
// Loads operand A, operand B and the opcode over a valid/ready port, holds them
// steady while the ALU settles, then captures the result and the overflow flag
// that belongs to the executed operation, with a one-cycle strobe and a counter.
module alu_op_sequencer #(
  parameter int NB_size = 16,
  parameter int NB_cnt  = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [1:0]         i_cmd,
  input  logic [NB_size-1:0] i_data,
  output logic               o_ready,
  output logic [1:0]         o_sel,
  output logic [NB_size-1:0] o_dataA,
  output logic [NB_size-1:0] o_dataB,
  input  logic [NB_size-1:0] i_dataC,
  input  logic               i_addCarry,
  input  logic               i_subCarry,
  output logic [NB_size-1:0] o_result,
  output logic               o_ovf,
  output logic               o_result_valid,
  output logic [NB_cnt-1:0]  o_exec_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_EXEC    = 2'b01,
    ST_CAPTURE = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    CMD_LOAD_A  = 2'b00,
    CMD_LOAD_B  = 2'b01,
    CMD_LOAD_OP = 2'b10,
    CMD_EXEC    = 2'b11
  } cmd_t;

  localparam logic [1:0] SEL_ADD = 2'b00;
  localparam logic [1:0] SEL_SUB = 2'b01;

  state_t               state_q, state_d;
  logic [NB_size-1:0]   data_a_q, data_a_d;
  logic [NB_size-1:0]   data_b_q, data_b_d;
  logic [1:0]           sel_q, sel_d;
  logic [NB_size-1:0]   result_q, result_d;
  logic                 ovf_q, ovf_d;
  logic                 result_valid_q, result_valid_d;
  logic [NB_cnt-1:0]    exec_count_q, exec_count_d;

  // Next-state and register-update logic for the IDLE -> EXEC -> CAPTURE cycle.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d        = state_q;
    data_a_d       = data_a_q;
    data_b_d       = data_b_q;
    sel_d          = sel_q;
    result_d       = result_q;
    ovf_d          = ovf_q;
    result_valid_d = 1'b0;
    exec_count_d   = exec_count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          unique case (cmd_t'(i_cmd))
            CMD_LOAD_A:  data_a_d = i_data;
            CMD_LOAD_B:  data_b_d = i_data;
            CMD_LOAD_OP: sel_d    = i_data[1:0];
            CMD_EXEC:    state_d  = ST_EXEC;
            default:     state_d  = ST_IDLE;
          endcase
        end
      end
      // ALU inputs are frozen here; this cycle only lets the ALU settle.
      ST_EXEC: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        result_d       = i_dataC;
        // Only add and sub have a meaningful overflow; logic ops report none.
        if (sel_q == SEL_ADD)      ovf_d = i_addCarry;
        else if (sel_q == SEL_SUB) ovf_d = i_subCarry;
        else                       ovf_d = 1'b0;
        result_valid_d = 1'b1;
        exec_count_d   = exec_count_q + NB_cnt'(1);
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of statement order.
    if (i_reset) begin
      state_q        <= ST_IDLE;
      data_a_q       <= '0;
      data_b_q       <= '0;
      sel_q          <= SEL_ADD;
      result_q       <= '0;
      ovf_q          <= 1'b0;
      result_valid_q <= 1'b0;
      exec_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      data_a_q       <= data_a_d;
      data_b_q       <= data_b_d;
      sel_q          <= sel_d;
      result_q       <= result_d;
      ovf_q          <= ovf_d;
      result_valid_q <= result_valid_d;
      exec_count_q   <= exec_count_d;
    end
  end

  assign o_ready        = (state_q == ST_IDLE);
  assign o_sel          = sel_q;
  assign o_dataA        = data_a_q;
  assign o_dataB        = data_b_q;
  assign o_result       = result_q;
  assign o_ovf          = ovf_q;
  assign o_result_valid = result_valid_q;
  assign o_exec_count   = exec_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Testbench for alu_op_sequencer: a behavioural ALU closes the loop, and a
// reference model built from plain integer arithmetic predicts each result.
module tb_alu_op_sequencer;

  localparam int NB_size = 16;
  localparam int NB_cnt  = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_valid;
  logic [1:0]         i_cmd;
  logic [NB_size-1:0] i_data;
  logic               o_ready;
  logic [1:0]         o_sel;
  logic [NB_size-1:0] o_dataA, o_dataB;
  logic [NB_size-1:0] alu_c;
  logic               add_v, sub_v;
  logic [NB_size-1:0] o_result;
  logic               o_ovf;
  logic               o_result_valid;
  logic [NB_cnt-1:0]  o_exec_count;
  logic               force_carry = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  logic [15:0] m_a, m_b, m_result;
  logic [1:0]  m_sel;
  logic        m_ovf;
  int          m_count;

  alu_op_sequencer #(.NB_size(NB_size), .NB_cnt(NB_cnt)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_valid        (i_valid),
    .i_cmd          (i_cmd),
    .i_data         (i_data),
    .o_ready        (o_ready),
    .o_sel          (o_sel),
    .o_dataA        (o_dataA),
    .o_dataB        (o_dataB),
    .i_dataC        (alu_c),
    .i_addCarry     (add_v | force_carry),
    .i_subCarry     (sub_v | force_carry),
    .o_result       (o_result),
    .o_ovf          (o_ovf),
    .o_result_valid (o_result_valid),
    .o_exec_count   (o_exec_count)
  );

  always #5 clk = ~clk;

  // Behavioural combinational ALU: both overflow flags are always computed.
  always_comb begin
    logic [15:0] add_s, sub_s;
    add_s = o_dataA + o_dataB;
    sub_s = o_dataA - o_dataB;
    add_v = (o_dataA[15] == o_dataB[15]) && (add_s[15] != o_dataA[15]);
    sub_v = (o_dataA[15] != o_dataB[15]) && (sub_s[15] != o_dataA[15]);
    alu_c = '0;
    case (o_sel)
      2'b00:   alu_c = add_s;
      2'b01:   alu_c = sub_s;
      2'b10:   alu_c = o_dataA & o_dataB;
      default: alu_c = o_dataA | o_dataB;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_a = '0; m_b = '0; m_sel = '0; m_result = '0; m_ovf = 1'b0; m_count = 0;
  endtask

  task automatic model_exec();
    int sa, sb, r;
    sa = int'($signed(m_a));
    sb = int'($signed(m_b));
    case (m_sel)
      2'd0: begin r = sa + sb; m_ovf = (r > 32767) || (r < -32768); end
      2'd1: begin r = sa - sb; m_ovf = (r > 32767) || (r < -32768); end
      2'd2: begin r = int'(m_a & m_b); m_ovf = 1'b0; end
      default: begin r = int'(m_a | m_b); m_ovf = 1'b0; end
    endcase
    m_result = r[15:0];
    m_count  = (m_count + 1) % 256;
  endtask

  task automatic load(input logic [1:0] cmd, input logic [15:0] data);
    check("ready_before_load", o_ready, 1'b1);
    i_valid = 1'b1; i_cmd = cmd; i_data = data;
    step();
    i_valid = 1'b0;
    case (cmd)
      2'd0: m_a = data;
      2'd1: m_b = data;
      default: m_sel = data[1:0];
    endcase
    check("load_dataA", o_dataA, m_a);
    check("load_dataB", o_dataB, m_b);
    check("load_sel", o_sel, m_sel);
  endtask

  // Execute; optionally hammer the busy cycles with a load A of 1 that must be dropped.
  task automatic execute(input bit junk_busy);
    i_valid = 1'b1; i_cmd = 2'b11; i_data = 16'($urandom);
    step();
    model_exec();
    check("busy1_ready", o_ready, 1'b0);
    check("busy1_valid", o_result_valid, 1'b0);
    if (junk_busy) begin
      i_valid = 1'b1; i_cmd = 2'b00; i_data = 16'd1;
    end else begin
      i_valid = 1'b0;
    end
    step();
    check("busy2_ready", o_ready, 1'b0);
    check("busy2_valid", o_result_valid, 1'b0);
    check("busy2_dataA", o_dataA, m_a);
    step();
    i_valid = 1'b0;
    check("strobe_valid", o_result_valid, 1'b1);
    check("strobe_result", o_result, m_result);
    check("strobe_ovf", o_ovf, m_ovf);
    check("strobe_count", o_exec_count, m_count);
    check("strobe_ready", o_ready, 1'b1);
    check("strobe_dataA", o_dataA, m_a);
  endtask

  task automatic idle_after_strobe();
    step();
    check("post_valid_low", o_result_valid, 1'b0);
    check("post_result_hold", o_result, m_result);
    check("post_ovf_hold", o_ovf, m_ovf);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, o_ready, 1'b1);
    check({tag, "_valid"}, o_result_valid, 1'b0);
    check({tag, "_result"}, o_result, 16'h0);
    check({tag, "_ovf"}, o_ovf, 1'b0);
    check({tag, "_count"}, o_exec_count, 8'h0);
    check({tag, "_dataA"}, o_dataA, 16'h0);
    check({tag, "_dataB"}, o_dataB, 16'h0);
    check({tag, "_sel"}, o_sel, 2'b00);
  endtask

  initial begin
    logic [15:0] neg_30000;
    neg_30000 = 16'(-30000);
    rst = 1'b1; i_valid = 1'b0; i_cmd = 2'b00; i_data = '0;
    model_reset();
    step();
    step();
    rst = 1'b0;
    check_reset_state("reset");

    // Plain add
    load(2'd0, 16'd10000); load(2'd1, 16'd5000); load(2'd2, 16'd0);
    execute(1'b0);
    check("tp_add_result", o_result, 16'd15000);
    check("tp_add_count", o_exec_count, 8'd1);
    idle_after_strobe();

    // Signed add overflow
    load(2'd0, 16'd30000); load(2'd1, 16'd30000);
    execute(1'b0);
    check("tp_addovf_result", o_result, 16'hEA60);
    check("tp_addovf_ovf", o_ovf, 1'b1);
    idle_after_strobe();

    // Signed sub overflow
    load(2'd2, 16'd1); load(2'd0, neg_30000); load(2'd1, 16'd30000);
    execute(1'b0);
    check("tp_subovf_result", o_result, 16'd5536);
    check("tp_subovf_ovf", o_ovf, 1'b1);
    idle_after_strobe();

    // Plain sub
    load(2'd0, 16'd10000); load(2'd1, 16'd5000);
    execute(1'b0);
    check("tp_sub_result", o_result, 16'd5000);
    check("tp_sub_ovf", o_ovf, 1'b0);
    // Re-execute without reload, accepted in the strobe cycle
    execute(1'b0);
    check("tp_reexec_result", o_result, 16'd5000);
    idle_after_strobe();

    // Logic ops ignore the carry inputs even when they are forced high
    force_carry = 1'b1;
    load(2'd0, 16'hAAAA); load(2'd1, 16'hCCCC); load(2'd2, 16'hFFF2);
    execute(1'b0);
    check("tp_and_result", o_result, 16'h8888);
    check("tp_and_ovf", o_ovf, 1'b0);
    load(2'd2, 16'd3);
    execute(1'b0);
    check("tp_or_result", o_result, 16'hEEEE);
    check("tp_or_ovf", o_ovf, 1'b0);
    force_carry = 1'b0;
    idle_after_strobe();

    // Commands during busy cycles are dropped; execute in the strobe cycle completes
    load(2'd0, 16'd7); load(2'd1, 16'd3); load(2'd2, 16'd0);
    execute(1'b1);
    check("tp_drop_dataA", o_dataA, 16'd7);
    execute(1'b0);
    check("tp_chain_result", o_result, 16'd10);
    idle_after_strobe();

    // Reset while in EXEC aborts the operation
    i_valid = 1'b1; i_cmd = 2'b11;
    step();
    i_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    check_reset_state("abort");
    step();
    check("abort_no_strobe", o_result_valid, 1'b0);
    check("abort_count_hold", o_exec_count, 8'h0);
    step();
    check("abort_no_strobe2", o_result_valid, 1'b0);

    // Counter wrap over 256 back-to-back executes
    load(2'd0, 16'd1); load(2'd1, 16'd2);
    for (int i = 0; i < 256; i++) begin
      execute(1'($urandom_range(0, 1)));
      if (i == 254) check("wrap_255", o_exec_count, 8'd255);
    end
    check("wrap_0", o_exec_count, 8'd0);
    idle_after_strobe();

    // Randomized loads and executes
    for (int i = 0; i < 80; i++) begin
      int unsigned r;
      r = $urandom_range(0, 3);
      if (r < 3) begin
        load(2'(r), 16'($urandom));
      end else begin
        execute(1'($urandom_range(0, 1)));
        if ($urandom_range(0, 1) == 1) idle_after_strobe();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
